// File: rtl/axi_write_master.sv
// AXI4 write-side DMA engine: drains a first-word-fall-through FIFO and writes
// the requested byte count to memory as INCR bursts that never cross a 4 KB page.
module axi_write_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MAX_BURST_LEN    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_start,
  input  logic [31:0]                     i_dst_addr,
  input  logic [31:0]                     i_total_len,
  output logic                            o_busy,
  output logic                            o_write_done,
  output logic                            o_write_error,
  input  logic                            i_fifo_empty,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_w_data,
  output logic                            o_fifo_pop,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  localparam int unsigned BEATS_W = 30;
  localparam int unsigned BURST_W = 9;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned PAGE_W  = 13;
  localparam int unsigned ADDR_W  = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [ADDR_W-1:0]    addr_q;
  logic [BEATS_W-1:0]   beats_left_q;
  logic [BURST_W-1:0]   burst_q;
  logic [LEN_W-1:0]     beat_cnt_q;

  logic [PAGE_W-1:0]    page_bytes_c;
  logic [BEATS_W-1:0]   page_beats_c;
  logic [BEATS_W-1:0]   burst_lim_c;
  logic [BURST_W-1:0]   burst_c;

  logic                 aw_hs_c;
  logic                 w_hs_c;
  logic                 b_hs_c;
  logic                 last_burst_c;
  logic [BEATS_W-1:0]   start_beats_c;

  logic                 awvalid_d;
  logic                 bready_d;
  logic                 busy_d;
  logic                 done_d;

  logic [1:0]           unused_len_lsb;

  assign unused_len_lsb = i_total_len[1:0];
  assign start_beats_c  = i_total_len[31:2];

  assign aw_hs_c      = m_axi_awvalid & m_axi_awready;
  assign w_hs_c       = m_axi_wvalid & m_axi_wready;
  assign b_hs_c       = m_axi_bvalid & m_axi_bready;
  assign last_burst_c = (beats_left_q == BEATS_W'(burst_q));

  // Burst size: bounded by remaining beats, max burst length and distance to the 4 KB page end
  always_comb begin
    page_bytes_c = PAGE_W'(4096) - PAGE_W'(addr_q[11:0]);
    page_beats_c = BEATS_W'(page_bytes_c >> 2);
    burst_lim_c  = beats_left_q;
    if (burst_lim_c > BEATS_W'(C_MAX_BURST_LEN)) begin
      burst_lim_c = BEATS_W'(C_MAX_BURST_LEN);
    end
    if (burst_lim_c > page_beats_c) begin
      burst_lim_c = page_beats_c;
    end
    burst_c = BURST_W'(burst_lim_c);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = (start_beats_c == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: state_d = S_AW;
      S_AW: begin
        if (aw_hs_c) begin
          state_d = S_W;
        end
      end
      S_W: begin
        if (w_hs_c && m_axi_wlast) begin
          state_d = S_B;
        end
      end
      S_B: begin
        if (b_hs_c) begin
          state_d = last_burst_c ? S_DONE : S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered handshake/status outputs
  always_comb begin
    awvalid_d = 1'b0;
    bready_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_AW:    awvalid_d = ~aw_hs_c;
      S_B:     bready_d  = ~b_hs_c;
      S_DONE:  done_d    = 1'b1;
      default: ;
    endcase
    case (state_d)
      S_CALC, S_AW, S_W, S_B: busy_d = 1'b1;
      default:                busy_d = 1'b0;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axi_awvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      o_busy        <= 1'b0;
      o_write_done  <= 1'b0;
    end else begin
      m_axi_awvalid <= awvalid_d;
      m_axi_bready  <= bready_d;
      o_busy        <= busy_d;
      o_write_done  <= done_d;
    end
  end

  // Transfer datapath: address, remaining beats, burst bookkeeping, sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= '0;
      beats_left_q  <= '0;
      burst_q       <= '0;
      beat_cnt_q    <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      o_write_error <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            addr_q        <= ADDR_W'(i_dst_addr);
            beats_left_q  <= start_beats_c;
            o_write_error <= 1'b0;
          end
        end
        S_CALC: begin
          burst_q      <= burst_c;
          m_axi_awaddr <= addr_q;
          m_axi_awlen  <= LEN_W'(burst_c - BURST_W'(1));
          beat_cnt_q   <= '0;
        end
        S_W: begin
          if (w_hs_c) begin
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
          end
        end
        S_B: begin
          if (b_hs_c) begin
            if (m_axi_bresp != 2'b00) begin
              o_write_error <= 1'b1;
            end
            addr_q       <= addr_q + ADDR_W'({burst_q, 2'b00});
            beats_left_q <= beats_left_q - BEATS_W'(burst_q);
          end
        end
        default: ;
      endcase
    end
  end

  // W channel follows the FIFO head directly; the FWFT FIFO holds data until popped
  assign m_axi_wvalid  = (state_q == S_W) & ~i_fifo_empty;
  assign m_axi_wlast   = (state_q == S_W) & (beat_cnt_q == m_axi_awlen);
  assign m_axi_wdata   = i_w_data;
  assign o_fifo_pop    = w_hs_c;

  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};

endmodule

// File: tb/tb_axi_write_master.sv
// Scoreboard bench for axi_write_master: a FIFO/slave agent checks AW and W
// traffic against queues filled by a burst-splitting reference model.
module tb_axi_write_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_dst_addr = '0;
  logic [31:0] i_total_len = '0;
  logic        o_busy, o_write_done, o_write_error;
  logic        i_fifo_empty = 1'b1;
  logic [31:0] i_w_data = '0;
  logic        o_fifo_pop;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b1;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b1;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  always #5 clk = ~clk;

  axi_write_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_MAX_BURST_LEN   (16)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_dst_addr(i_dst_addr),
    .i_total_len(i_total_len), .o_busy(o_busy), .o_write_done(o_write_done),
    .o_write_error(o_write_error), .i_fifo_empty(i_fifo_empty), .i_w_data(i_w_data),
    .o_fifo_pop(o_fifo_pop), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [39:0] exp_aw[$];
  logic [32:0] exp_w[$];
  logic [31:0] fifo_q[$];
  logic [1:0]  bresp_q[$];

  int done_seen   = 0;
  int b_pending   = 0;
  int popped      = 0;
  int stall_after = -1;
  int stall_left  = 0;
  bit rnd_ready   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference burst split: fills the FIFO and the expected AW/W queues
  task automatic load_xfer(input logic [31:0] addr, input logic [31:0] len);
    logic [29:0] beats;
    logic [31:0] a;
    logic [31:0] d;
    int          b;
    int          page;
    beats = len[31:2];
    a     = addr;
    while (beats != 0) begin
      page = (4096 - int'(a[11:0])) / 4;
      b    = (beats > 30'd16) ? 16 : int'(beats);
      if (b > page) b = page;
      exp_aw.push_back({a, 8'(b - 1)});
      for (int i = 0; i < b; i++) begin
        d = $urandom;
        fifo_q.push_back(d);
        exp_w.push_back({(i == b - 1), d});
      end
      a     = a + 32'(b * 4);
      beats = beats - 30'(b);
    end
  endtask

  // FIFO + AXI slave agent: checks at negedge, drives just after posedge
  always begin
    logic aw_hs, w_hs, b_hs, wl;
    @(negedge clk);
    aw_hs = m_axi_awvalid & m_axi_awready;
    w_hs  = m_axi_wvalid & m_axi_wready;
    b_hs  = m_axi_bvalid & m_axi_bready;
    wl    = m_axi_wlast;
    if (aw_hs) begin
      if (exp_aw.size() == 0) check("aw_extra", 64'(exp_aw.size()), 64'd1);
      else check("aw", {24'h0, m_axi_awaddr, m_axi_awlen}, {24'h0, exp_aw.pop_front()});
      check("aw_attr", {59'h0, m_axi_awsize, m_axi_awburst}, {59'h0, 3'b010, 2'b01});
    end
    if (w_hs) begin
      if (exp_w.size() == 0) check("w_extra", 64'(exp_w.size()), 64'd1);
      else check("w", {31'h0, wl, m_axi_wdata}, {31'h0, exp_w.pop_front()});
      check("wstrb", {60'h0, m_axi_wstrb}, 64'hF);
    end
    if (m_axi_wvalid || o_fifo_pop) check("pop", {63'h0, o_fifo_pop}, {63'h0, w_hs});
    if (stall_left > 0) check("stall_wv", {63'h0, m_axi_wvalid}, 64'h0);
    if (o_write_done) done_seen++;
    @(posedge clk);
    #1;
    if (stall_left > 0) stall_left--;
    if (w_hs) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      popped++;
      if (popped == stall_after) stall_left = 5;
      if (wl) b_pending++;
    end
    if (b_hs) begin
      m_axi_bvalid = 1'b0;
      b_pending--;
    end
    if (!m_axi_bvalid && b_pending > 0) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = (bresp_q.size() != 0) ? bresp_q.pop_front() : 2'b00;
    end
    m_axi_awready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_wready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (reset) begin
      exp_aw.delete();
      exp_w.delete();
      fifo_q.delete();
      bresp_q.delete();
      b_pending    = 0;
      stall_left   = 0;
      m_axi_bvalid = 1'b0;
    end
    i_fifo_empty = (fifo_q.size() == 0) || (stall_left > 0);
    i_w_data     = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  end

  task automatic pulse_start(input logic [31:0] addr, input logic [31:0] len);
    @(posedge clk);
    #1;
    i_dst_addr  = addr;
    i_total_len = len;
    i_start     = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] len,
                          input logic exp_err, input bit chk_lat);
    int d0;
    d0 = done_seen;
    load_xfer(addr, len);
    pulse_start(addr, len);
    check("busy_on", {63'h0, o_busy}, 64'h1);
    check("err_clr", {63'h0, o_write_error}, 64'h0);
    if (chk_lat) begin
      check("lat_n0", {63'h0, m_axi_awvalid}, 64'h0);
      @(posedge clk);
      #1;
      check("lat_n1", {63'h0, m_axi_awvalid}, 64'h0);
      @(posedge clk);
      #1;
      check("lat_n2", {63'h0, m_axi_awvalid}, 64'h1);
    end
    for (int c = 0; c < 4000 && done_seen == d0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("done_cnt", 64'(done_seen), 64'(d0 + 1));
    check("aw_left", 64'(exp_aw.size()), 64'h0);
    check("w_left", 64'(exp_w.size()), 64'h0);
    check("err", {63'h0, o_write_error}, {63'h0, exp_err});
    check("busy_off", {63'h0, o_busy}, 64'h0);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {57'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_fifo_pop,
                      o_write_done, o_busy, o_write_error}, 64'h0);
    check("rst_aw", {24'h0, m_axi_awaddr, m_axi_awlen}, 64'h0);
    reset = 1'b0;

    // 16 B single burst with start-to-AW latency check
    run_xfer(32'h0000_0000, 32'd16, 1'b0, 1'b1);
    // 128 B: two full bursts
    run_xfer(32'h0000_0100, 32'd128, 1'b0, 1'b0);
    // 4 KB page split
    run_xfer(32'h0000_0FF8, 32'd16, 1'b0, 1'b0);
    // FIFO empty for 5 cycles after beat 2
    stall_after = popped + 2;
    run_xfer(32'h0000_0200, 32'd16, 1'b0, 1'b0);
    stall_after = -1;
    // Error response on first of two bursts
    bresp_q.push_back(2'b10);
    bresp_q.push_back(2'b00);
    run_xfer(32'h0000_0400, 32'd128, 1'b1, 1'b0);
    // Error cleared by next start; address wraps at 2^32
    run_xfer(32'hFFFF_FFF8, 32'd16, 1'b0, 1'b0);
    // Length ignores the two low bits
    run_xfer(32'h0000_0800, 32'd23, 1'b0, 1'b0);

    // Zero length: done two cycles after start, no bus activity
    d0 = done_seen;
    pulse_start(32'h0000_1234, 32'd3);
    check("z_busy", {62'h0, o_busy, o_write_done}, 64'h0);
    @(posedge clk);
    #1;
    check("z_done", {63'h0, o_write_done}, 64'h1);
    @(posedge clk);
    #1;
    check("z_done_off", {63'h0, o_write_done}, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("z_cnt", 64'(done_seen), 64'(d0 + 1));

    // Random ready stalls with page-straddling addresses
    rnd_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      run_xfer(32'h0000_3000 + 32'(4 * $urandom_range(980, 1023)),
               32'(4 * $urandom_range(1, 48)), 1'b0, 1'b0);
    end
    rnd_ready = 1'b0;

    // Reset mid-burst aborts immediately
    load_xfer(32'h0000_2000, 32'd64);
    pulse_start(32'h0000_2000, 32'd64);
    for (int c = 0; c < 200 && popped < 1; c++) @(posedge clk);
    d0 = popped;
    for (int c = 0; c < 200 && popped < d0 + 2; c++) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("rst_mid", {57'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_fifo_pop,
                      o_write_done, o_busy, o_write_error}, 64'h0);
    check("rst_mid_aw", {24'h0, m_axi_awaddr, m_axi_awlen}, 64'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Clean transfer after the abort
    run_xfer(32'h0000_5000, 32'd32, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
